// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and its picker.
// State encoding and byte width are common to every file of the block.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational one-hot picker: first set request at or above the pointer,
// wrapping around; with round-robin disabled the pointer is treated as 0.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_rr_mode,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx,
    output logic [NUM_REQ-1:0] o_onehot
);

    logic [IDX_W-1:0] w_base;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    assign w_base  = i_rr_mode ? i_ptr : '0;
    assign o_valid = |i_req;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path can infer a latch.
        o_idx    = '0;
        o_onehot = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, w_base} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX controller among NUM_REQ byte sources: grant, latch the
// byte, hold the controller enable until frame-done, then ack the winner.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RR_MODE = 1
) (
    input  logic                      sysclk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      tx_en_sig,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_done_sig
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_busy;
    logic               r_tx_en;
    logic [BYTE_W-1:0]  r_tx_data;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_winner;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [BYTE_W-1:0]  w_pick_byte;
    logic [IDX_W-1:0]   w_next_ptr;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_ptr     (r_rr_ptr),
        .i_rr_mode (RR_MODE != 0),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx),
        .o_onehot  (w_pick_oh)
    );

    // One-hot mux of the winning requester's byte.
    always_comb begin
        w_pick_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick_oh[k]) begin
                w_pick_byte = req_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_next_ptr = (r_winner == IDX_W'(NUM_REQ-1)) ? '0 : r_winner + 1'b1;

    always_ff @(posedge sysclk or negedge rst_n) begin
        // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ack     <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
            r_rr_ptr  <= '0;
            r_winner  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant   <= w_pick_oh;
                        r_winner  <= w_pick_idx;
                        r_tx_data <= w_pick_byte;
                        r_tx_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                // Enable drops on the edge after done so the controller parks at start.
                ST_SEND: begin
                    if (tx_done_sig) begin
                        r_tx_en  <= 1'b0;
                        r_ack    <= r_grant;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign tx_en_sig = r_tx_en;
    assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter, each
// paired with a simple serialising TX controller model.
module tb_uart_tx_arbiter;

    localparam int BIT_CYC   = 4;
    localparam int FRAME_CYC = 11 * BIT_CYC;
    localparam int ACK_WAIT  = 400;

    typedef struct packed {
        logic [3:0] oh;
        logic [7:0] data;
    } exp_t;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [3:0]  req       [2];
    logic [31:0] req_data  [2];
    logic [3:0]  ack       [2];
    logic [3:0]  grant     [2];
    logic        busy      [2];
    logic        tx_en     [2];
    logic [7:0]  tx_data   [2];
    logic        tx_done   [2];
    logic        done_model[2];
    logic        done_force[2];

    // TX model state
    logic        m_act [2];
    logic        m_lock[2];
    int          m_cnt [2];
    logic [7:0]  m_byte[2];
    logic        m_par [2];

    // Monitor state
    logic        prev_en  [2];
    logic [3:0]  prev_ack [2];
    logic [3:0]  mon_grant[2];
    logic [7:0]  mon_data [2];
    int          low_cnt  [2];
    logic        had_frame[2];
    logic        b2b      [2];

    exp_t exp_q[2][$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 sysclk = ~sysclk;

    assign tx_done[0] = done_model[0] | done_force[0];
    assign tx_done[1] = done_model[1] | done_force[1];

    uart_tx_arbiter #(.NUM_REQ(4), .RR_MODE(1)) u_dut_rr (
        .sysclk(sysclk), .rst_n(rst_n), .req(req[0]), .req_data(req_data[0]),
        .ack(ack[0]), .grant(grant[0]), .busy(busy[0]), .tx_en_sig(tx_en[0]),
        .tx_data(tx_data[0]), .tx_done_sig(tx_done[0])
    );

    uart_tx_arbiter #(.NUM_REQ(4), .RR_MODE(0)) u_dut_fp (
        .sysclk(sysclk), .rst_n(rst_n), .req(req[1]), .req_data(req_data[1]),
        .ack(ack[1]), .grant(grant[1]), .busy(busy[1]), .tx_en_sig(tx_en[1]),
        .tx_data(tx_data[1]), .tx_done_sig(tx_done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic push(input int d, input logic [3:0] oh, input logic [7:0] data);
        exp_q[d].push_back('{oh: oh, data: data});
    endtask

    task automatic set_byte(input int d, input int k, input logic [7:0] v);
        req_data[d][8*k +: 8] = v;
    endtask

    task automatic wait_ack(input int d);
        int k;
        k = 0;
        do begin
            @(negedge sysclk);
            k++;
        end while (ack[d] == 4'b0 && k < ACK_WAIT);
        check($sformatf("ack_seen_d%0d", d), {31'b0, ack[d] != 4'b0}, 32'd1);
    endtask

    // Serialiser model: start, 8 data bits LSB first, even parity, stop.
    // Data and parity are sampled from tx_data live at each bit start.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d]      <= 1'b0;
                m_lock[d]     <= 1'b0;
                m_cnt[d]      <= 0;
                m_byte[d]     <= '0;
                m_par[d]      <= 1'b0;
                done_model[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                done_model[d] <= 1'b0;
                if (!tx_en[d]) m_lock[d] <= 1'b0;
                if (m_act[d]) begin
                    if (m_cnt[d] % BIT_CYC == 0) begin
                        if (m_cnt[d] / BIT_CYC >= 1 && m_cnt[d] / BIT_CYC <= 8)
                            m_byte[d][m_cnt[d]/BIT_CYC-1] <= tx_data[d][m_cnt[d]/BIT_CYC-1];
                        else if (m_cnt[d] / BIT_CYC == 9)
                            m_par[d] <= ^tx_data[d];
                    end
                    if (m_cnt[d] == FRAME_CYC - 1) begin
                        m_act[d]      <= 1'b0;
                        m_lock[d]     <= 1'b1;
                        done_model[d] <= 1'b1;
                    end
                    m_cnt[d] <= m_cnt[d] + 1;
                end else if (tx_en[d] && !m_lock[d]) begin
                    m_act[d] <= 1'b1;
                    m_cnt[d] <= 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and checks the finished frame.
    always @(negedge sysclk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                prev_en[d]   <= 1'b0;
                prev_ack[d]  <= '0;
                low_cnt[d]   <= 0;
                had_frame[d] <= 1'b0;
            end else begin
                if (tx_en[d] && !prev_en[d]) begin
                    mon_grant[d] <= grant[d];
                    mon_data[d]  <= tx_data[d];
                    if (b2b[d] && had_frame[d])
                        check($sformatf("gap_cycles_d%0d", d), low_cnt[d], 32'd2);
                end
                if (tx_en[d] && prev_en[d]) begin
                    check($sformatf("grant_stable_d%0d", d), {28'b0, grant[d]}, {28'b0, mon_grant[d]});
                    check($sformatf("data_stable_d%0d", d), {24'b0, tx_data[d]}, {24'b0, mon_data[d]});
                end
                low_cnt[d] <= tx_en[d] ? 0 : low_cnt[d] + 1;
                if (done_model[d])
                    check($sformatf("en_at_done_d%0d", d), {31'b0, tx_en[d]}, 32'd1);
                if (ack[d] != 4'b0) begin
                    had_frame[d] <= 1'b1;
                    check($sformatf("ack_single_d%0d", d), {28'b0, prev_ack[d]}, 32'd0);
                    check($sformatf("en_low_at_ack_d%0d", d), {31'b0, tx_en[d]}, 32'd0);
                    check($sformatf("grant_clr_at_ack_d%0d", d), {28'b0, grant[d]}, 32'd0);
                    check($sformatf("busy_in_gap_d%0d", d), {31'b0, busy[d]}, 32'd1);
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("unexpected_ack_d%0d", d), {28'b0, ack[d]}, 32'd0);
                    end else begin
                        check($sformatf("ack_owner_d%0d", d), {28'b0, ack[d]}, {28'b0, exp_q[d][0].oh});
                        check($sformatf("grant_owner_d%0d", d), {28'b0, mon_grant[d]}, {28'b0, exp_q[d][0].oh});
                        check($sformatf("tx_data_d%0d", d), {24'b0, mon_data[d]}, {24'b0, exp_q[d][0].data});
                        check($sformatf("serial_byte_d%0d", d), {24'b0, m_byte[d]}, {24'b0, exp_q[d][0].data});
                        check($sformatf("serial_parity_d%0d", d), {31'b0, m_par[d]}, {31'b0, ^exp_q[d][0].data});
                        void'(exp_q[d].pop_front());
                    end
                end
                if (prev_ack[d] != 4'b0 && ack[d] == 4'b0)
                    check($sformatf("busy_after_gap_d%0d", d), {31'b0, busy[d]}, 32'd0);
                prev_en[d]  <= tx_en[d];
                prev_ack[d] <= ack[d];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d]        = '0;
            req_data[d]   = '0;
            done_force[d] = 1'b0;
            b2b[d]        = 1'b0;
        end

        // Reset values
        cyc(2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ack_d%0d", d), {28'b0, ack[d]}, 32'd0);
            check($sformatf("rst_grant_d%0d", d), {28'b0, grant[d]}, 32'd0);
            check($sformatf("rst_busy_d%0d", d), {31'b0, busy[d]}, 32'd0);
            check($sformatf("rst_en_d%0d", d), {31'b0, tx_en[d]}, 32'd0);
            check($sformatf("rst_data_d%0d", d), {24'b0, tx_data[d]}, 32'd0);
        end
        rst_n = 1'b1;
        cyc(2);

        // Round-robin from pointer 0, then wrap from pointer 3 to 0
        b2b[0] = 1'b1;
        set_byte(0, 0, 8'h11);
        set_byte(0, 2, 8'h33);
        req[0] = 4'b0101;
        push(0, 4'b0001, 8'h11);
        push(0, 4'b0100, 8'h33);
        push(0, 4'b0001, 8'h11);
        push(0, 4'b0100, 8'h33);
        push(0, 4'b1000, 8'hC3);
        push(0, 4'b0001, 8'h3C);
        wait_ack(0);
        wait_ack(0);
        wait_ack(0);
        wait_ack(0);
        set_byte(0, 0, 8'h3C);
        set_byte(0, 3, 8'hC3);
        req[0] = 4'b1001;
        wait_ack(0);
        req[0] = 4'b0001;
        wait_ack(0);
        req[0] = 4'b0000;
        b2b[0] = 1'b0;
        cyc(2);

        // Single request: one-cycle latency to enable
        set_byte(0, 0, 8'hA5);
        req[0] = 4'b0001;
        push(0, 4'b0001, 8'hA5);
        cyc(1);
        check("lat_en", {31'b0, tx_en[0]}, 32'd1);
        check("lat_data", {24'b0, tx_data[0]}, 32'h0000_00A5);
        check("lat_grant", {28'b0, grant[0]}, 32'd1);
        check("lat_busy", {31'b0, busy[0]}, 32'd1);
        wait_ack(0);
        req[0] = 4'b0000;
        cyc(2);

        // Data changed mid-frame is ignored; stray done in GAP and IDLE ignored;
        // a request dropped during SEND still completes
        set_byte(0, 0, 8'h5A);
        req[0] = 4'b0001;
        push(0, 4'b0001, 8'h5A);
        cyc(12);
        set_byte(0, 0, 8'hFF);
        wait_ack(0);
        push(0, 4'b0001, 8'hFF);
        done_force[0] = 1'b1;
        cyc(1);
        done_force[0] = 1'b0;
        cyc(12);
        req[0] = 4'b0000;
        wait_ack(0);
        cyc(2);
        done_force[0] = 1'b1;
        cyc(1);
        done_force[0] = 1'b0;
        check("idle_done_busy", {31'b0, busy[0]}, 32'd0);
        check("idle_done_en", {31'b0, tx_en[0]}, 32'd0);
        cyc(1);
        check("idle_done_ack", {28'b0, ack[0]}, 32'd0);

        // Fixed priority: requester 1 wins while it holds req, then requester 2
        set_byte(1, 1, 8'h21);
        set_byte(1, 2, 8'h42);
        set_byte(1, 3, 8'h84);
        req[1] = 4'b1110;
        push(1, 4'b0010, 8'h21);
        push(1, 4'b0010, 8'h21);
        push(1, 4'b0010, 8'h21);
        push(1, 4'b0100, 8'h42);
        cyc(1);
        check("fp_lat_grant", {28'b0, grant[1]}, 32'd2);
        wait_ack(1);
        wait_ack(1);
        wait_ack(1);
        req[1] = 4'b1100;
        wait_ack(1);
        req[1] = 4'b0000;
        cyc(2);

        // Reset mid-frame: outputs clear at once, no ack, pointer back to 0
        set_byte(0, 1, 8'h77);
        req[0] = 4'b0010;
        cyc(12);
        check("pre_rst_en", {31'b0, tx_en[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", {31'b0, tx_en[0]}, 32'd0);
        check("mid_rst_grant", {28'b0, grant[0]}, 32'd0);
        check("mid_rst_ack", {28'b0, ack[0]}, 32'd0);
        check("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
        check("mid_rst_data", {24'b0, tx_data[0]}, 32'd0);
        cyc(3);
        set_byte(0, 0, 8'h96);
        set_byte(0, 1, 8'h69);
        req[0] = 4'b0011;
        push(0, 4'b0001, 8'h96);
        push(0, 4'b0010, 8'h69);
        rst_n = 1'b1;
        wait_ack(0);
        req[0] = 4'b0010;
        wait_ack(0);
        req[0] = 4'b0000;
        cyc(4);

        check("q_empty_d0", exp_q[0].size(), 32'd0);
        check("q_empty_d1", exp_q[1].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
